// File: rtl/cr16_controller.sv
// Fetch/decode/execute control FSM for cr16_datapath; owns the PC and the latched status flags.
// Optional CR16_CTRL_ILLEGAL_TRAP_EN: reserved opcodes halt the controller until reset.
module cr16_controller #(
    parameter int                     PC_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0,
    parameter logic [3:0]             CMP_OPCODE = 4'hB
) (
    input  logic                  I_CLK,
    input  logic                  I_NRESET,
    input  logic                  I_ENABLE,
    output logic [PC_WIDTH-1:0]   O_INSTR_ADDR,
    output logic                  O_INSTR_REQ,
    input  logic                  I_INSTR_VALID,
    input  logic [15:0]           I_INSTR,
    input  logic [4:0]            I_STATUS_FLAGS,
    output logic [15:0]           O_REG_WRITE_ENABLE,
    output logic [3:0]            O_REG_A_SELECT,
    output logic [3:0]            O_REG_B_SELECT,
    output logic [3:0]            O_OPCODE,
    output logic [15:0]           O_IMMEDIATE,
    output logic                  O_IMMEDIATE_SELECT,
    output logic                  O_HALTED
);
    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

    state_t                state, state_next;
    logic [PC_WIDTH-1:0]   pc, pc_next;
    logic [15:0]           ir;
    logic [4:0]            flags;
    logic [3:0]            a_sel, b_sel, opcode;
    logic [15:0]           imm;
    logic                  imm_sel, is_alu, is_branch, write_ok, taken;
    logic [15:0]           we;
    logic [3:0]            dec_op, dec_alu_op;
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
    logic                  is_reserved;
`endif

    // Flags are {N,Z,F,L,C}; the condition code lives in the Rdest field.
    function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
        logic n, z, ff, l, cy;
        {n, z, ff, l, cy} = f;
        case (c)
            4'h0: cond_true = z;
            4'h1: cond_true = !z;
            4'h2: cond_true = cy;
            4'h3: cond_true = !cy;
            4'h4: cond_true = l;
            4'h5: cond_true = !l;
            4'h6: cond_true = n;
            4'h7: cond_true = !n;
            4'h8: cond_true = ff;
            4'h9: cond_true = !ff;
            4'hA: cond_true = !l && !z;
            4'hB: cond_true = l || z;
            4'hC: cond_true = !n && !z;
            4'hD: cond_true = n || z;
            4'hE: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    endfunction

    assign dec_op     = ir[15:12];
    assign dec_alu_op = (dec_op == 4'h0) ? ir[7:4] : dec_op;
    assign taken      = is_branch && cond_true(a_sel, flags);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        we         = '0;
        case (state)
            FETCH:   if (I_ENABLE && I_INSTR_VALID) state_next = DECODE;
            DECODE:  if (I_ENABLE) state_next = EXECUTE;
            EXECUTE: begin
                if (I_ENABLE) begin
                    state_next = FETCH;
                    pc_next    = taken ? pc + {{(PC_WIDTH-8){imm[7]}}, imm[7:0]}
                                       : pc + 1'b1;
                    if (write_ok) we = 16'h0001 << a_sel;
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
                    if (is_reserved) begin
                        state_next = HALT;
                        pc_next    = pc;
                    end
`endif
                end
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) state <= FETCH;
        else if (I_ENABLE) state <= state_next;
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            pc        <= RESET_PC;
            ir        <= '0;
            flags     <= '0;
            a_sel     <= '0;
            b_sel     <= '0;
            opcode    <= '0;
            imm       <= '0;
            imm_sel   <= 1'b0;
            is_alu    <= 1'b0;
            is_branch <= 1'b0;
            write_ok  <= 1'b0;
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
            is_reserved <= 1'b0;
`endif
        end else if (I_ENABLE) begin
            pc <= pc_next;
            if (state == FETCH && I_INSTR_VALID) ir <= I_INSTR;
            if (state == DECODE) begin
                a_sel     <= ir[11:8];
                b_sel     <= ir[3:0];
                opcode    <= dec_alu_op;
                imm       <= {{8{ir[7]}}, ir[7:0]};
                imm_sel   <= (dec_op != 4'h0) && (dec_op <= 4'hB);
                is_alu    <= dec_op <= 4'hB;
                is_branch <= dec_op == 4'hC;
                write_ok  <= (dec_op <= 4'hB) && (dec_alu_op != CMP_OPCODE);
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
                is_reserved <= dec_op >= 4'hD;
`endif
            end
            if (state == EXECUTE && is_alu) flags <= I_STATUS_FLAGS;
        end
    end

    // REQ drops while reset is asserted even though the state already reads FETCH.
    assign O_INSTR_REQ        = (state == FETCH) && I_NRESET;
    assign O_INSTR_ADDR       = pc;
    assign O_REG_WRITE_ENABLE = we;
    assign O_REG_A_SELECT     = a_sel;
    assign O_REG_B_SELECT     = b_sel;
    assign O_OPCODE           = opcode;
    assign O_IMMEDIATE        = imm;
    assign O_IMMEDIATE_SELECT = imm_sel;
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
    assign O_HALTED           = (state == HALT);
`else
    assign O_HALTED           = 1'b0;
`endif

endmodule

// File: tb/tb_cr16_controller.sv
// Self-checking bench for cr16_controller: directed cases then random instructions against an ISA-level model.
module tb_cr16_controller;
    logic        I_CLK, I_NRESET, I_ENABLE, I_INSTR_VALID;
    logic [15:0] I_INSTR;
    logic [4:0]  I_STATUS_FLAGS;
    logic [15:0] O_INSTR_ADDR, O_REG_WRITE_ENABLE, O_IMMEDIATE;
    logic        O_INSTR_REQ, O_IMMEDIATE_SELECT, O_HALTED;
    logic [3:0]  O_REG_A_SELECT, O_REG_B_SELECT, O_OPCODE;

    int errors = 0;
    int checks = 0;
    logic [15:0] mpc;
    logic [4:0]  mflags;

    cr16_controller dut (
        .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_ENABLE(I_ENABLE),
        .O_INSTR_ADDR(O_INSTR_ADDR), .O_INSTR_REQ(O_INSTR_REQ),
        .I_INSTR_VALID(I_INSTR_VALID), .I_INSTR(I_INSTR),
        .I_STATUS_FLAGS(I_STATUS_FLAGS), .O_REG_WRITE_ENABLE(O_REG_WRITE_ENABLE),
        .O_REG_A_SELECT(O_REG_A_SELECT), .O_REG_B_SELECT(O_REG_B_SELECT),
        .O_OPCODE(O_OPCODE), .O_IMMEDIATE(O_IMMEDIATE),
        .O_IMMEDIATE_SELECT(O_IMMEDIATE_SELECT), .O_HALTED(O_HALTED)
    );

    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Branch condition table written straight from the ISA definition.
    function automatic logic cond_holds(input logic [3:0] c, input logic [4:0] f);
        logic n, z, fl, l, cy;
        logic [15:0] tbl;
        n = f[4]; z = f[3]; fl = f[2]; l = f[1]; cy = f[0];
        tbl = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !fl, fl,
               !n, n, !l, l, !cy, cy, !z, z};
        return tbl[c];
    endfunction

    task automatic do_reset();
        I_NRESET = 1'b0;
        I_INSTR_VALID = 1'b0;
        #1;
        chk("rst_req", O_INSTR_REQ, 0);
        chk("rst_we", O_REG_WRITE_ENABLE, 0);
        chk("rst_opcode", O_OPCODE, 0);
        chk("rst_imm", O_IMMEDIATE, 0);
        chk("rst_asel", O_REG_A_SELECT, 0);
        chk("rst_addr", O_INSTR_ADDR, 0);
        @(negedge I_CLK);
        I_NRESET = 1'b1;
        mpc = 16'h0000;
        mflags = 5'b0;
        #1;
        chk("rel_req", O_INSTR_REQ, 1);
        chk("rel_addr", O_INSTR_ADDR, 0);
        chk("rel_halted", O_HALTED, 0);
    endtask

    // Entry and exit: just after a falling edge, controller in FETCH.
    task automatic exec(input logic [15:0] instr, input logic [4:0] sf, input int stall, input int fdelay);
        logic [3:0]  op, exp_opc;
        logic        alu, branch, tk;
        logic [15:0] exp_we, exp_imm;
        op      = instr[15:12];
        exp_opc = (op == 4'h0) ? instr[7:4] : op;
        alu     = op <= 4'hB;
        branch  = op == 4'hC;
        exp_imm = {{8{instr[7]}}, instr[7:0]};
        exp_we  = (alu && exp_opc != 4'hB) ? (16'h0001 << instr[11:8]) : 16'h0000;
        tk      = branch && cond_holds(instr[11:8], mflags);

        chk("fetch_req", O_INSTR_REQ, 1);
        chk("fetch_addr", O_INSTR_ADDR, mpc);
        chk("fetch_we", O_REG_WRITE_ENABLE, 0);
        for (int i = 0; i < fdelay; i++) begin
            if ($urandom_range(1) == 1) begin
                I_ENABLE = 1'b0; I_INSTR_VALID = 1'b1; I_INSTR = 16'($urandom);
            end else begin
                I_ENABLE = 1'b1; I_INSTR_VALID = 1'b0;
            end
            @(negedge I_CLK);
            chk("fetch_wait_req", O_INSTR_REQ, 1);
        end
        I_ENABLE = 1'b1; I_INSTR_VALID = 1'b1; I_INSTR = instr;
        @(negedge I_CLK);
        I_INSTR_VALID = 1'b0; I_INSTR = 16'($urandom);
        chk("dec_we", O_REG_WRITE_ENABLE, 0);
        chk("dec_req", O_INSTR_REQ, 0);
        @(negedge I_CLK);
        for (int i = 0; i < stall; i++) begin
            I_ENABLE = 1'b0;
            I_STATUS_FLAGS = 5'($urandom);
            #1;
            chk("stall_we", O_REG_WRITE_ENABLE, 0);
            @(negedge I_CLK);
        end
        I_ENABLE = 1'b1;
        I_STATUS_FLAGS = sf;
        #1;
        chk("ex_we", O_REG_WRITE_ENABLE, exp_we);
        chk("ex_asel", O_REG_A_SELECT, instr[11:8]);
        if (alu) begin
            chk("ex_opcode", O_OPCODE, exp_opc);
            chk("ex_bsel", O_REG_B_SELECT, instr[3:0]);
            chk("ex_immsel", O_IMMEDIATE_SELECT, op != 4'h0);
            if (op != 4'h0) chk("ex_imm", O_IMMEDIATE, exp_imm);
        end
        @(negedge I_CLK);
`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
        if (op >= 4'hD) begin
            for (int i = 0; i < 3; i++) begin
                chk("halt_flag", O_HALTED, 1);
                chk("halt_req", O_INSTR_REQ, 0);
                chk("halt_we", O_REG_WRITE_ENABLE, 0);
                chk("halt_addr", O_INSTR_ADDR, mpc);
                @(negedge I_CLK);
            end
            $display("instr %h sf %b -> halted at pc %h", instr, sf, mpc);
            return;
        end
`endif
        if (alu) mflags = sf;
        mpc = tk ? mpc + exp_imm : mpc + 16'h0001;
        chk("next_addr", O_INSTR_ADDR, mpc);
        chk("next_we", O_REG_WRITE_ENABLE, 0);
        chk("halted", O_HALTED, 0);
        $display("instr %h sf %b stall %0d -> next pc %h", instr, sf, stall, mpc);
    endtask

    initial begin
        logic [15:0] r_instr;
        int max_op;
        I_NRESET = 1'b0; I_ENABLE = 1'b1; I_INSTR_VALID = 1'b0;
        I_INSTR = '0; I_STATUS_FLAGS = '0;
        mpc = '0; mflags = '0;
        @(negedge I_CLK);
        do_reset();

        exec(16'h53FF, 5'b10101, 0, 0);
        exec(16'h0251, 5'b00000, 0, 1);
        exec(16'h01B2, 5'b01000, 0, 0);
        exec(16'hC004, 5'b00000, 0, 2);
        exec(16'hC104, 5'b00000, 0, 0);
        exec(16'h0251, 5'b00110, 3, 0);

        do_reset();
        exec(16'h1000, 5'b00000, 0, 0);
        exec(16'hCEFE, 5'b00000, 0, 0);
        exec(16'h0251, 5'b00000, 0, 0);

        // Mid-fetch reset with a valid word already offered.
        I_INSTR_VALID = 1'b1; I_INSTR = 16'h3123;
        do_reset();

`ifdef CR16_CTRL_ILLEGAL_TRAP_EN
        max_op = 12;
`else
        max_op = 15;
`endif
        for (int k = 0; k < 60; k++) begin
            r_instr = 16'($urandom);
            r_instr[15:12] = 4'($urandom_range(max_op));
            exec(r_instr, 5'($urandom), $urandom_range(2), $urandom_range(2));
        end

        exec(16'hF000, 5'b00000, 0, 0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
